// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle RV32M multiply/divide unit. It latches op1/op2/funct3 on an
//   accepted start, iterates one bit per cycle, applies sign correction, and
//   presents a registered result together with a one-cycle done pulse.
//
// Ports
//   clk     : system clock, rising edge
//   rstn    : asynchronous active-low reset
//   start   : operation request, only accepted while idle
//   funct3  : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//             100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op1     : rs1 operand
//   op2     : operand 2
//   flush   : abort the in-flight operation (no done, result kept)
//   busy    : high while an operation is in progress
//   done    : one-cycle pulse, result valid
//   result  : registered result, changes only when done rises or on reset
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0] LASTCOUNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        opReg;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opB;
  logic              negRes;
  logic              negRem;
  logic              fast;
  logic [XLEN-1:0]   fastRes;

  logic              signedA;
  logic              signedB;
  logic              aNegIn;
  logic              bNegIn;
  logic [XLEN-1:0]   aMagIn;
  logic [XLEN-1:0]   bMagIn;
  logic              divZero;
  logic              divOvf;
  logic              fastIn;
  logic [XLEN-1:0]   fastResIn;

  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulNext;
  logic [XLEN:0]     divTrial;
  logic [2*XLEN-1:0] divNext;

  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quoFix;
  logic [XLEN-1:0]   remFix;
  logic [XLEN-1:0]   finValue;

  // Operand preparation for an incoming request: decide which operands are
  // signed, take magnitudes, and detect the divide-by-zero and signed
  // overflow cases that are answered without iterating.
  always_comb begin
    signedA   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    signedB   = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                (funct3 == 3'b110);
    aNegIn    = signedA & op1[XLEN-1];
    bNegIn    = signedB & op2[XLEN-1];
    aMagIn    = aNegIn ? -op1 : op1;
    bMagIn    = bNegIn ? -op2 : op2;
    divZero   = (op2 == '0);
    divOvf    = !funct3[0] && (op1 == MINV) && (op2 == '1);
    fastIn    = funct3[2] && (divZero || divOvf);
    fastResIn = '0;
    if (divZero) begin
      fastResIn = funct3[1] ? op1 : '1;
    end else begin
      fastResIn = funct3[1] ? '0 : MINV;
    end
  end

  // One iteration step for each algorithm. The multiplier sits in the low
  // half of acc and shifts out as the partial product shifts in from the
  // top. For division the low half holds the dividend, which becomes the
  // quotient, and the high half accumulates the partial remainder.
  always_comb begin
    mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} +
               (acc[0] ? {1'b0, opB} : {(XLEN+1){1'b0}});
    mulNext  = {mulSum, acc[XLEN-1:1]};
    divTrial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opB};
    if (!divTrial[XLEN]) begin
      divNext = {divTrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      divNext = {acc[2*XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and output-half selection used in FIN.
  always_comb begin
    prodFix  = negRes ? -acc : acc;
    quoFix   = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remFix   = negRem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    finValue = '0;
    case (opReg)
      3'b000:                 finValue = prodFix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: finValue = prodFix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         finValue = quoFix;
      default:                finValue = remFix;
    endcase
    if (fast) begin
      finValue = fastRes;
    end
  end

  // Control FSM with registered busy/done/result. A start coinciding with
  // done is refused so a consumer that reacts to done combinationally
  // cannot accidentally launch a second operation on the same pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      count   <= '0;
      opReg   <= '0;
      acc     <= '0;
      opB     <= '0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      fast    <= 1'b0;
      fastRes <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush && !done) begin
            opReg   <= funct3;
            count   <= '0;
            fast    <= fastIn;
            fastRes <= fastResIn;
            negRes  <= aNegIn ^ bNegIn;
            negRem  <= funct3[2] & aNegIn;
            if (funct3[2]) begin
              acc <= {{XLEN{1'b0}}, aMagIn};
              opB <= bMagIn;
            end else begin
              acc <= {{XLEN{1'b0}}, bMagIn};
              opB <= aMagIn;
            end
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (fast) begin
            state <= FIN;
          end else begin
            acc   <= opReg[2] ? divNext : mulNext;
            count <= count + 1'b1;
            if (count == LASTCOUNT) begin
              state <= FIN;
            end
          end
        end
        FIN: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            result <= finValue;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
